grant_tracker: RTL and testbench

//  Requester-side companion of the round-robin arbiter's fixed priority stage. Holds up to N

---
 rtl/grant_tracker_pkg.sv | 24 ++
 rtl/grant_tracker_if.sv | 45 ++++
 rtl/grant_tracker_req_slot.sv | 30 +++
 rtl/grant_tracker.sv | 130 +++++++++++++
 tb/tb_grant_tracker.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grant_tracker_pkg.sv
// Shared types and helpers for the grant tracker: FSM state encoding, default sizes
// and the one-hot to binary index conversion.
package grant_tracker_pkg;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int N_DEF     = 4;
    localparam int LEN_W_DEF = 4;

    // Lowest set bit wins, which matches the arbiter's fixed priority.
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/grant_tracker_if.sv
// Bus between the requesters/arbiter and the grant tracker.
// Optional macro GRANT_ONEHOT_CHECK_EN adds the sticky err_onehot flag.
interface grant_tracker_if
    import grant_tracker_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LEN_W = LEN_W_DEF
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Handshake: req/arb_en are registered; the arbiter answers with a registered
    // one-hot grant one cycle later, which is only sampled while arb_en is high.
    // The owner then gets exactly len+1 cycles with beat_ok high before done pulses.
    logic [N-1:0]       start;
    logic [N*LEN_W-1:0] len;
    logic [N-1:0]       grant;
    logic               beat_ok;
    logic [N-1:0]       req;
    logic               arb_en;
    logic               busy;
    logic [IDX_W-1:0]   owner_idx;
    logic [N-1:0]       done;
    logic               err_spur;
`ifdef GRANT_ONEHOT_CHECK_EN
    logic               err_onehot;
`endif
    state_t             state;

    modport master (
        output start, len, grant, beat_ok,
        input  req, arb_en, busy, owner_idx, done, err_spur, state
`ifdef GRANT_ONEHOT_CHECK_EN
        , input err_onehot
`endif
    );

    modport slave (
        input  start, len, grant, beat_ok,
        output req, arb_en, busy, owner_idx, done, err_spur, state
`ifdef GRANT_ONEHOT_CHECK_EN
        , output err_onehot
`endif
    );

endinterface

// File: rtl/grant_tracker_req_slot.sv
// One requester slot: pending flag plus the length captured with its start pulse.
module req_slot #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [LEN_W-1:0] len_in,
    output logic             pending,
    output logic [LEN_W-1:0] len_q
);
    logic set_en;

    // A start on an idle slot, or on the slot being released this cycle, re-arms it.
    assign set_en = start && (!pending || clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            len_q   <= '0;
        end else if (set_en) begin
            pending <= 1'b1;
            len_q   <= len_in;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/grant_tracker.sv
// Grant tracker top: request slots, ARB/XFER/DONE FSM, beat counter and grant error flags.
// Macro GRANT_ONEHOT_CHECK_EN rejects multi-hot grants instead of taking the lowest bit.
module grant_tracker
    import grant_tracker_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    grant_tracker_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               spur_q, spur_d;
    logic [N-1:0]       pending;
    logic [N-1:0]       clr_vec;
    logic [LEN_W-1:0]   len_store [N];
    logic [N-1:0]       grant_sel;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_hit;

    for (genvar i = 0; i < N; i++) begin : g_slot
        req_slot #(.LEN_W(LEN_W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (bus.start[i]),
            .clr     (clr_vec[i]),
            .len_in  (bus.len[i*LEN_W +: LEN_W]),
            .pending (pending[i]),
            .len_q   (len_store[i])
        );
    end

`ifdef GRANT_ONEHOT_CHECK_EN
    logic onehot_q, onehot_d;
    logic multi_hot;

    assign multi_hot = |(bus.grant & (bus.grant - N'(1)));
    assign grant_sel = bus.grant;
`else
    assign grant_sel = bus.grant & (~bus.grant + N'(1));
`endif

    assign grant_idx = IDX_W'(onehot_to_idx(32'(grant_sel)));
    assign grant_hit = |(grant_sel & pending);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        spur_d  = 1'b0;
        clr_vec = '0;
`ifdef GRANT_ONEHOT_CHECK_EN
        onehot_d = onehot_q;
`endif
        unique case (state_q)
            ST_ARB: begin
                if (bus.grant != '0) begin
`ifdef GRANT_ONEHOT_CHECK_EN
                    if (multi_hot) begin
                        onehot_d = 1'b1;
                    end else if (grant_hit) begin
                        owner_d = grant_idx;
                        cnt_d   = len_store[grant_idx];
                        state_d = ST_XFER;
                    end else begin
                        spur_d = 1'b1;
                    end
`else
                    if (grant_hit) begin
                        owner_d = grant_idx;
                        cnt_d   = len_store[grant_idx];
                        state_d = ST_XFER;
                    end else begin
                        spur_d = 1'b1;
                    end
`endif
                end
            end
            ST_XFER: begin
                // cnt holds the remaining beats minus one, so it stops at zero.
                if (bus.beat_ok) begin
                    if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
                    else             state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                clr_vec[owner_q] = 1'b1;
                state_d          = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            cnt_q   <= '0;
            owner_q <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            spur_q  <= spur_d;
        end
    end

`ifdef GRANT_ONEHOT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) onehot_q <= 1'b0;
        else        onehot_q <= onehot_d;
    end

    assign bus.err_onehot = onehot_q;
`endif

    assign bus.req       = pending;
    assign bus.arb_en    = (state_q == ST_ARB);
    assign bus.busy      = (state_q == ST_XFER);
    assign bus.owner_idx = owner_q;
    assign bus.done      = clr_vec;
    assign bus.err_spur  = spur_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_grant_tracker.sv
// Bench for grant_tracker: directed scenarios plus a randomized run against a transaction-level model.
module tb_grant_tracker;
    import grant_tracker_pkg::*;

    localparam int N     = 4;
    localparam int LEN_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    grant_tracker_if #(.N(N), .LEN_W(LEN_W)) bus ();

    grant_tracker #(.N(N), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: owner >= 0 while a transfer runs, left = beats still owed,
    // done_own >= 0 during the release cycle.
    bit              m_pend [N];
    int              m_len  [N];
    int              m_owner;
    int              m_left;
    int              m_done_own;
    bit              m_spur;
    bit              m_onehot;
    logic [N-1:0]    exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_len[i]  = 0;
        end
        m_owner    = -1;
        m_left     = 0;
        m_done_own = -1;
        m_spur     = 1'b0;
        m_onehot   = 1'b0;
        exp_q.delete();
    endfunction

    function automatic int lowest(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    function automatic void model_step();
        int  release_own;
        int  next_done;
        int  b;
        bit  reject;
        logic [N-1:0] oh;
        release_own = m_done_own;
        next_done   = -1;
        m_spur      = 1'b0;
        reject      = 1'b0;
        if (release_own >= 0) begin
            // release cycle: nothing else happens
        end else if (m_owner >= 0) begin
            if (bus.beat_ok) begin
                m_left--;
                if (m_left == 0) begin
                    next_done = m_owner;
                    m_owner   = -1;
                end
            end
        end else if (bus.grant != '0) begin
            b = lowest(bus.grant);
`ifdef GRANT_ONEHOT_CHECK_EN
            reject = ($countones(bus.grant) > 1);
`endif
            if (reject) begin
                m_onehot = 1'b1;
            end else if (m_pend[b]) begin
                m_owner = b;
                m_left  = m_len[b] + 1;
                oh      = '0;
                oh[b]   = 1'b1;
                exp_q.push_back(oh);
            end else begin
                m_spur = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.start[i] && (!m_pend[i] || release_own == i)) begin
                m_pend[i] = 1'b1;
                m_len[i]  = int'(bus.len[i*LEN_W +: LEN_W]);
            end else if (release_own == i) begin
                m_pend[i] = 1'b0;
            end
        end
        m_done_own = next_done;
    endfunction

    function automatic logic [N-1:0] exp_req();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_done();
        logic [N-1:0] v;
        v = '0;
        if (m_done_own >= 0) v[m_done_own] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        if (rst_n) model_step();
        else       model_reset();
        @(posedge clk);
        #1;
        bus.start   = '0;
        bus.grant   = '0;
        bus.beat_ok = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.start   = '0;
        bus.len     = '0;
        bus.grant   = '0;
        bus.beat_ok = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_len(input int i, input int l);
        bus.len[i*LEN_W +: LEN_W] = LEN_W'(l);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus.req !== 4'b0000) begin miscompares++; $display("FAIL rst_req got=%b exp=0000", bus.req); end
        vectors++; if (bus.arb_en !== 1'b1) begin miscompares++; $display("FAIL rst_arb_en got=%b exp=1", bus.arb_en); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.done !== 4'b0000) begin miscompares++; $display("FAIL rst_done got=%b exp=0000", bus.done); end
        vectors++; if (bus.err_spur !== 1'b0) begin miscompares++; $display("FAIL rst_spur got=%b exp=0", bus.err_spur); end
        vectors++; if (bus.owner_idx !== 2'd0) begin miscompares++; $display("FAIL rst_owner got=%0d exp=0", bus.owner_idx); end
`ifdef GRANT_ONEHOT_CHECK_EN
        vectors++; if (bus.err_onehot !== 1'b0) begin miscompares++; $display("FAIL rst_onehot got=%b exp=0", bus.err_onehot); end
`endif
    endtask

    task automatic test_single();
        do_reset();
        bus.start = 4'b0100; set_len(2, 2); tick();
        vectors++; if (bus.req !== 4'b0100) begin miscompares++; $display("FAIL t1_req got=%b exp=0100", bus.req); end
        bus.grant = 4'b0100; tick();
        vectors++; if (bus.busy !== 1'b1 || bus.arb_en !== 1'b0) begin miscompares++; $display("FAIL t1_busy got=%b/%b exp=1/0", bus.busy, bus.arb_en); end
        vectors++; if (bus.owner_idx !== 2'd2) begin miscompares++; $display("FAIL t1_owner got=%0d exp=2", bus.owner_idx); end
        for (int k = 0; k < 3; k++) begin
            bus.beat_ok = 1'b1; tick();
            if (k < 2) begin
                vectors++; if (bus.done !== 4'b0000 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL t1_early_done beat=%0d got=%b exp=0000", k, bus.done); end
            end
        end
        vectors++; if (bus.done !== 4'b0100) begin miscompares++; $display("FAIL t1_done got=%b exp=0100", bus.done); end
        tick();
        vectors++; if (bus.req !== 4'b0000 || bus.arb_en !== 1'b1) begin miscompares++; $display("FAIL t1_release got=%b/%b exp=0000/1", bus.req, bus.arb_en); end
    endtask

    task automatic test_two_starts();
        do_reset();
        bus.start = 4'b1001; set_len(0, 1); set_len(3, 0); tick();
        vectors++; if (bus.req !== 4'b1001) begin miscompares++; $display("FAIL t2_req got=%b exp=1001", bus.req); end
        bus.grant = 4'b0001; tick();
        vectors++; if (bus.owner_idx !== 2'd0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL t2_owner0 got=%0d exp=0", bus.owner_idx); end
        bus.beat_ok = 1'b1; tick();
        bus.beat_ok = 1'b1; tick();
        vectors++; if (bus.done !== 4'b0001) begin miscompares++; $display("FAIL t2_done0 got=%b exp=0001", bus.done); end
        tick();
        vectors++; if (bus.arb_en !== 1'b1 || bus.req !== 4'b1000) begin miscompares++; $display("FAIL t2_rearb got=%b/%b exp=1/1000", bus.arb_en, bus.req); end
        bus.grant = 4'b1000; tick();
        vectors++; if (bus.owner_idx !== 2'd3 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL t2_owner3 got=%0d exp=3", bus.owner_idx); end
        bus.beat_ok = 1'b1; tick();
        vectors++; if (bus.done !== 4'b1000) begin miscompares++; $display("FAIL t2_done3 got=%b exp=1000", bus.done); end
        tick();
        vectors++; if (bus.req !== 4'b0000) begin miscompares++; $display("FAIL t2_req_end got=%b exp=0000", bus.req); end
    endtask

    task automatic test_beat_gaps();
        do_reset();
        bus.start = 4'b0010; set_len(1, 3); tick();
        bus.grant = 4'b0010; tick();
        for (int k = 0; k < 4; k++) begin
            bus.beat_ok = 1'b1; tick();
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    vectors++; if (bus.done !== 4'b0000 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL t3_gap beat=%0d got=%b/%b exp=0000/1", k, bus.done, bus.busy); end
                    tick();
                end
            end
        end
        vectors++; if (bus.done !== 4'b0010) begin miscompares++; $display("FAIL t3_done got=%b exp=0010", bus.done); end
    endtask

    task automatic test_multi_hot();
        do_reset();
        bus.start = 4'b0011; set_len(0, 0); set_len(1, 0); tick();
        bus.grant = 4'b0011; tick();
`ifdef GRANT_ONEHOT_CHECK_EN
        vectors++; if (bus.err_onehot !== 1'b1) begin miscompares++; $display("FAIL t4_onehot got=%b exp=1", bus.err_onehot); end
        vectors++; if (bus.state !== ST_ARB || bus.busy !== 1'b0) begin miscompares++; $display("FAIL t4_state got=%0d exp=0", bus.state); end
        bus.grant = 4'b0010; tick();
        vectors++; if (bus.owner_idx !== 2'd1 || bus.err_onehot !== 1'b1) begin miscompares++; $display("FAIL t4_sticky got=%0d/%b exp=1/1", bus.owner_idx, bus.err_onehot); end
        do_reset();
        vectors++; if (bus.err_onehot !== 1'b0) begin miscompares++; $display("FAIL t4_clear got=%b exp=0", bus.err_onehot); end
`else
        vectors++; if (bus.owner_idx !== 2'd0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL t4_lowest got=%0d/%b exp=0/1", bus.owner_idx, bus.busy); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.start = 4'b1000; set_len(3, 3); tick();
        bus.grant = 4'b1000; tick();
        bus.beat_ok = 1'b1; tick();
        bus.beat_ok = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.req !== 4'b0000 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL t5_async got=%b/%b exp=0000/0", bus.req, bus.busy); end
        vectors++; if (bus.arb_en !== 1'b1 || bus.done !== 4'b0000) begin miscompares++; $display("FAIL t5_arb got=%b/%b exp=1/0000", bus.arb_en, bus.done); end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.beat_ok = 1'b1; tick();
            vectors++; if (bus.done !== 4'b0000 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL t5_no_done cyc=%0d got=%b exp=0000", k, bus.done); end
        end
    endtask

    task automatic test_spur_rearm();
        do_reset();
        bus.start = 4'b0001; set_len(0, 0); tick();
        bus.grant = 4'b0100; tick();
        vectors++; if (bus.err_spur !== 1'b1) begin miscompares++; $display("FAIL t6_spur got=%b exp=1", bus.err_spur); end
        vectors++; if (bus.arb_en !== 1'b1 || bus.busy !== 1'b0 || bus.req !== 4'b0001) begin miscompares++; $display("FAIL t6_arb got=%b/%b/%b exp=1/0/0001", bus.arb_en, bus.busy, bus.req); end
        tick();
        vectors++; if (bus.err_spur !== 1'b0) begin miscompares++; $display("FAIL t6_spur_pulse got=%b exp=0", bus.err_spur); end
        bus.start = 4'b0010; set_len(1, 0); tick();
        bus.grant = 4'b0010; tick();
        bus.beat_ok = 1'b1; tick();
        vectors++; if (bus.done !== 4'b0010) begin miscompares++; $display("FAIL t6_done1 got=%b exp=0010", bus.done); end
        bus.start = 4'b0010; set_len(1, 1); tick();
        vectors++; if (bus.req !== 4'b0011 || bus.arb_en !== 1'b1) begin miscompares++; $display("FAIL t6_rearm got=%b/%b exp=0011/1", bus.req, bus.arb_en); end
        bus.grant = 4'b0010; tick();
        bus.beat_ok = 1'b1; tick();
        vectors++; if (bus.done !== 4'b0000 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL t6_newlen got=%b exp=0000", bus.done); end
        bus.beat_ok = 1'b1; tick();
        vectors++; if (bus.done !== 4'b0010) begin miscompares++; $display("FAIL t6_done2 got=%b exp=0010", bus.done); end
    endtask

    task automatic test_random();
        int r;
        int s;
        logic [N-1:0] pend_v;
        logic [N-1:0] got;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.start[i] = 1'b1;
                    set_len(i, ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)));
                end
            end
            bus.beat_ok = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            pend_v = exp_req();
            if (r < 6 && pend_v != '0) begin
                s = int'($urandom_range(0, N - 1));
                while (!pend_v[s]) s = (s + 1) % N;
                bus.grant = '0;
                bus.grant[s] = 1'b1;
            end else if (r == 6) begin
                bus.grant = N'($urandom_range(1, 15));
            end
            tick();
            vectors++; if (bus.req !== exp_req()) begin miscompares++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", c, bus.req, exp_req()); end
            vectors++; if (bus.arb_en !== (m_owner < 0 && m_done_own < 0)) begin miscompares++; $display("FAIL rnd_arb_en cyc=%0d got=%b", c, bus.arb_en); end
            vectors++; if (bus.busy !== (m_owner >= 0)) begin miscompares++; $display("FAIL rnd_busy cyc=%0d got=%b", c, bus.busy); end
            if (m_owner >= 0) begin
                vectors++; if (int'(bus.owner_idx) != m_owner) begin miscompares++; $display("FAIL rnd_owner cyc=%0d got=%0d exp=%0d", c, bus.owner_idx, m_owner); end
            end
            vectors++; if (bus.done !== exp_done()) begin miscompares++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", c, bus.done, exp_done()); end
            vectors++; if (bus.err_spur !== m_spur) begin miscompares++; $display("FAIL rnd_spur cyc=%0d got=%b exp=%b", c, bus.err_spur, m_spur); end
`ifdef GRANT_ONEHOT_CHECK_EN
            vectors++; if (bus.err_onehot !== m_onehot) begin miscompares++; $display("FAIL rnd_onehot cyc=%0d got=%b exp=%b", c, bus.err_onehot, m_onehot); end
`endif
            got = bus.done;
            if (got != '0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL rnd_sb cyc=%0d got=%b exp=none", c, got);
                end else if (got !== exp_q[0]) begin
                    miscompares++; $display("FAIL rnd_sb cyc=%0d got=%b exp=%b", c, got, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        bus.start   = '0;
        bus.len     = '0;
        bus.grant   = '0;
        bus.beat_ok = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_two_starts();
        test_beat_gaps();
        test_multi_hot();
        test_reset_mid();
        test_spur_rearm();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
